// File: rtl/uart_crc_pkg.sv
// Shared definitions for the CRC-16 UART transmit path: CRC-16/CCITT-FALSE constants
// and the scheduler FSM state encoding.
package uart_crc_pkg;

   localparam logic [15:0] CRC16_CCITT_POLY = 16'h1021;
   localparam logic [15:0] CRC16_CCITT_INIT = 16'hFFFF;

   typedef enum logic [1:0] {
      IDLE,
      CRC,
      LAUNCH,
      WAIT_DONE
   } sched_state_e;

endpackage

// File: rtl/crc16_serial_step.sv
// Bit-serial CRC-16 engine: load seeds crc with INIT ^ {byte, 8'h00}, then each step
// shifts one bit MSB-first; done pulses on the step that completes the byte.
module crc16_serial_step
   import uart_crc_pkg::*;
#(
   parameter logic [15:0] POLY = CRC16_CCITT_POLY,
   parameter logic [15:0] INIT = CRC16_CCITT_INIT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        load_i,
   input  logic [7:0]  data_i,
   input  logic        step_i,
   output logic [15:0] crc_o,
   output logic        done_o
);

   logic [15:0] crc_q, crc_d;
   logic [2:0]  bit_q, bit_d;

   // Load has priority over step so a new byte always starts from a clean seed.
   always_comb begin
      crc_d = crc_q;
      bit_d = bit_q;
      if (load_i) begin
         crc_d = INIT ^ {data_i, 8'h00};
         bit_d = 3'd0;
      end else if (step_i) begin
         crc_d = crc_q[15] ? ({crc_q[14:0], 1'b0} ^ POLY) : {crc_q[14:0], 1'b0};
         bit_d = bit_q + 3'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         crc_q <= '0;
         bit_q <= '0;
      end else begin
         crc_q <= crc_d;
         bit_q <= bit_d;
      end
   end

   assign crc_o  = crc_q;
   assign done_o = step_i && !load_i && (bit_q == 3'd7);

endmodule

// File: rtl/uart_crc_tx_scheduler.sv
// Round-robin scheduler sharing one CRC-16 UART transmitter between NUM_REQ byte
// requesters: grant, compute CRC bit-serially, launch, and wait for the frame to end.
module uart_crc_tx_scheduler
   import uart_crc_pkg::*;
#(
   parameter int          NUM_REQ        = 4,
   parameter logic [15:0] CRC_POLY       = CRC16_CCITT_POLY,
   parameter logic [15:0] CRC_INIT       = CRC16_CCITT_INIT,
   parameter int          LAUNCH_TIMEOUT = 16,
   localparam int         GW             = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [8*NUM_REQ-1:0] req_data,
   output logic [NUM_REQ-1:0]   req_ready,
   output logic [7:0]           tx_data,
   output logic [15:0]          tx_crc,
   output logic                 tx_start,
   input  logic                 tx_busy,
   output logic [GW-1:0]        grant_id,
   output logic                 frame_done,
   output logic                 launch_err
);

   localparam int TW = $clog2(LAUNCH_TIMEOUT + 1);

   sched_state_e state_q, state_d;
   logic [GW-1:0] ptr_q, ptr_d;
   logic [GW-1:0] grant_q, grant_d;
   logic [7:0]    data_q, data_d;
   logic [TW-1:0] tout_q, tout_d;
   logic          frame_done_q, frame_done_d;
   logic          launch_err_q, launch_err_d;

   logic [GW-1:0] idx;
   logic [GW-1:0] pick;
   logic [GW-1:0] next_ptr;
   logic          found;
   logic          accept;
   logic          crc_load;
   logic          crc_step;
   logic          crc_done;

   // First valid requester at or after the RR pointer, wrapping around.
   always_comb begin
      found = 1'b0;
      pick  = '0;
      idx   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = GW'((int'(ptr_q) + k) % NUM_REQ);
         if (!found && req_valid[idx]) begin
            found = 1'b1;
            pick  = idx;
         end
      end
   end

   // Grants are held off while the line is busy, including a frame left over from before reset.
   assign accept   = (state_q == IDLE) && !reset && !tx_busy && found;
   assign next_ptr = (grant_q == GW'(NUM_REQ - 1)) ? '0 : grant_q + GW'(1);

   always_comb begin
      req_ready = '0;
      if (accept) begin
         req_ready[pick] = 1'b1;
      end
   end

   crc16_serial_step #(
      .POLY (CRC_POLY),
      .INIT (CRC_INIT)
   ) u_crc (
      .clk    (clk),
      .reset  (reset),
      .load_i (crc_load),
      .data_i (req_data[{pick, 3'b000} +: 8]),
      .step_i (crc_step),
      .crc_o  (tx_crc),
      .done_o (crc_done)
   );

   // Next-state logic; the RR pointer moves past the granted requester on success or timeout.
   always_comb begin
      state_d      = state_q;
      ptr_d        = ptr_q;
      grant_d      = grant_q;
      data_d       = data_q;
      tout_d       = '0;
      frame_done_d = 1'b0;
      launch_err_d = 1'b0;
      crc_load     = 1'b0;
      crc_step     = 1'b0;
      tx_start     = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               grant_d  = pick;
               data_d   = req_data[{pick, 3'b000} +: 8];
               crc_load = 1'b1;
               state_d  = CRC;
            end
         end
         CRC: begin
            crc_step = 1'b1;
            if (crc_done) begin
               state_d = LAUNCH;
            end
         end
         LAUNCH: begin
            if (tx_busy) begin
               state_d = WAIT_DONE;
            end else begin
               tx_start = 1'b1;
               if (tout_q == TW'(LAUNCH_TIMEOUT - 1)) begin
                  launch_err_d = 1'b1;
                  ptr_d        = next_ptr;
                  state_d      = IDLE;
               end else begin
                  tout_d = tout_q + TW'(1);
               end
            end
         end
         WAIT_DONE: begin
            if (!tx_busy) begin
               frame_done_d = 1'b1;
               ptr_d        = next_ptr;
               state_d      = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         ptr_q        <= '0;
         grant_q      <= '0;
         data_q       <= '0;
         tout_q       <= '0;
         frame_done_q <= 1'b0;
         launch_err_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         grant_q      <= grant_d;
         data_q       <= data_d;
         tout_q       <= tout_d;
         frame_done_q <= frame_done_d;
         launch_err_q <= launch_err_d;
      end
   end

   assign tx_data    = data_q;
   assign grant_id   = grant_q;
   assign frame_done = frame_done_q;
   assign launch_err = launch_err_q;

endmodule

// File: tb/tb_uart_crc_tx_scheduler.sv
// Directed plus randomized bench for uart_crc_tx_scheduler, checked against a
// reference model of the round-robin choice and the CRC-16/CCITT-FALSE value.
module tb_uart_crc_tx_scheduler;

   localparam int N  = 4;
   localparam int GW = $clog2(N);

   logic           clk = 1'b0;
   logic           reset = 1'b1;
   logic [N-1:0]   req_valid = '0;
   logic [8*N-1:0] req_data = '0;
   logic [N-1:0]   req_ready;
   logic [7:0]     tx_data;
   logic [15:0]    tx_crc;
   logic           tx_start;
   logic           tx_busy = 1'b0;
   logic [GW-1:0]  grant_id;
   logic           frame_done;
   logic           launch_err;

   int testsRun  = 0;
   int failCount = 0;
   int fdCount   = 0;
   int modelPtr  = 0;

   uart_crc_tx_scheduler #(
      .NUM_REQ        (N),
      .CRC_POLY       (16'h1021),
      .CRC_INIT       (16'hFFFF),
      .LAUNCH_TIMEOUT (16)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_data   (req_data),
      .req_ready  (req_ready),
      .tx_data    (tx_data),
      .tx_crc     (tx_crc),
      .tx_start   (tx_start),
      .tx_busy    (tx_busy),
      .grant_id   (grant_id),
      .frame_done (frame_done),
      .launch_err (launch_err)
   );

   always #5 clk = ~clk;

   // Counts every frame_done pulse seen on the port.
   always @(negedge clk) begin
      if (frame_done === 1'b1) fdCount++;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   // CRC-16/CCITT-FALSE over one byte, classic MSB-first division form.
   function automatic logic [15:0] crcModel(input logic [7:0] d);
      logic [15:0] c;
      logic        fb;
      c = 16'hFFFF;
      for (int b = 7; b >= 0; b--) begin
         fb = c[15] ^ d[b];
         c  = {c[14:0], 1'b0};
         if (fb) c = c ^ 16'h1021;
      end
      return c;
   endfunction

   function automatic int pickModel(input logic [N-1:0] v, input int ptr);
      for (int k = 0; k < N; k++) begin
         if (v[(ptr + k) % N]) return (ptr + k) % N;
      end
      return -1;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      testsRun++;
      assert (obs === exp) else begin
         failCount++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic toDrive;
      @(posedge clk);
      #1;
   endtask

   task automatic toSample;
      @(negedge clk);
   endtask

   task automatic applyReset(input logic busyLevel, input logic [N-1:0] v);
      toDrive;
      reset     = 1'b1;
      tx_busy   = busyLevel;
      req_valid = v;
      toSample;
      toDrive;
      toSample;
      checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
      checkOutput("rst_tx_data", 32'(tx_data), 32'd0);
      checkOutput("rst_tx_crc", 32'(tx_crc), 32'd0);
      checkOutput("rst_tx_start", 32'(tx_start), 32'd0);
      checkOutput("rst_grant_id", 32'(grant_id), 32'd0);
      checkOutput("rst_frame_done", 32'(frame_done), 32'd0);
      checkOutput("rst_launch_err", 32'(launch_err), 32'd0);
      toDrive;
      reset = 1'b0;
      toSample;
      modelPtr = 0;
   endtask

   // Runs one complete grant; entry and exit are both at a negedge sample point.
   task automatic applyStimulus(input bit timeoutMode, input bit keepValid, output int obsGrant);
      int           cyc;
      int           expIdx;
      int           ix;
      logic [N-1:0] expRdy;
      logic [7:0]   expData;
      logic [15:0]  expCrc;
      obsGrant = -1;
      cyc = 0;
      while (req_ready === '0 && cyc < 40) begin
         toDrive;
         toSample;
         cyc++;
      end
      checkOutput("accept_wait", 32'(cyc < 40), 32'd1);
      if (cyc >= 40) return;
      expIdx  = pickModel(req_valid, modelPtr);
      expRdy  = (expIdx >= 0) ? (N'(1) << expIdx) : '0;
      ix      = (expIdx >= 0) ? expIdx : 0;
      checkOutput("req_ready", 32'(req_ready), 32'(expRdy));
      expData = req_data[8*ix +: 8];
      expCrc  = crcModel(expData);
      toDrive;
      if (keepValid) req_data[8*ix +: 8] = 8'($urandom);
      else req_valid = '0;
      toSample;
      cyc = 1;
      while (tx_start !== 1'b1 && cyc < 30) begin
         toDrive;
         toSample;
         cyc++;
      end
      checkOutput("start_latency", 32'(cyc), 32'd9);
      checkOutput("tx_data", 32'(tx_data), 32'(expData));
      checkOutput("tx_crc", 32'(tx_crc), 32'(expCrc));
      checkOutput("grant_id", 32'(grant_id), 32'(ix));
      obsGrant = int'(grant_id);
      if (timeoutMode) begin
         cyc = 1;
         for (int i = 0; i < 40; i++) begin
            toDrive;
            toSample;
            if (tx_start !== 1'b1) break;
            cyc++;
         end
         checkOutput("start_high_cycles", 32'(cyc), 32'd16);
         checkOutput("launch_err", 32'(launch_err), 32'd1);
         modelPtr = (ix + 1) % N;
         toDrive;
         toSample;
         checkOutput("launch_err_pulse", 32'(launch_err), 32'd0);
      end else begin
         repeat ($urandom_range(0, 3)) begin
            toDrive;
            toSample;
         end
         checkOutput("start_hold", 32'(tx_start), 32'd1);
         toDrive;
         tx_busy = 1'b1;
         toSample;
         checkOutput("start_drop", 32'(tx_start), 32'd0);
         repeat ($urandom_range(1, 4)) begin
            toDrive;
            toSample;
         end
         checkOutput("data_stable", 32'(tx_data), 32'(expData));
         checkOutput("crc_stable", 32'(tx_crc), 32'(expCrc));
         checkOutput("done_early", 32'(frame_done), 32'd0);
         toDrive;
         tx_busy = 1'b0;
         toSample;
         toDrive;
         toSample;
         checkOutput("frame_done", 32'(frame_done), 32'd1);
         modelPtr = (ix + 1) % N;
      end
   endtask

   initial begin
      int g;
      int fdBefore;
      bit sawRdy;
      int order [5];
      order = '{0, 1, 2, 3, 0};

      // Single request, byte 0x00.
      applyReset(1'b0, '0);
      toDrive;
      req_valid = 4'b0001;
      req_data[7:0] = 8'h00;
      toSample;
      applyStimulus(1'b0, 1'b0, g);
      checkOutput("crc_00", 32'(tx_crc), 32'h0000E1F0);

      // Byte 0xFF from requester 1.
      toDrive;
      req_valid = 4'b0010;
      req_data[15:8] = 8'hFF;
      toSample;
      applyStimulus(1'b0, 1'b0, g);
      checkOutput("crc_ff", 32'(tx_crc), 32'h0000FF00);
      checkOutput("data_ff", 32'(tx_data), 32'h000000FF);

      // All requesters valid continuously.
      applyReset(1'b0, '0);
      toDrive;
      req_valid = '1;
      req_data  = $urandom;
      toSample;
      fdBefore = fdCount;
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b0, 1'b1, g);
         checkOutput("rr_order", 32'(g), 32'(order[i]));
      end
      #1;
      checkOutput("frame_done_count", 32'(fdCount - fdBefore), 32'd5);

      // Transmitter never goes busy.
      applyReset(1'b0, '0);
      toDrive;
      req_valid = 4'b0101;
      req_data  = $urandom;
      toSample;
      applyStimulus(1'b1, 1'b0, g);
      checkOutput("timeout_grant", 32'(g), 32'd0);
      toDrive;
      req_valid = 4'b0101;
      toSample;
      applyStimulus(1'b0, 1'b0, g);
      checkOutput("after_timeout_grant", 32'(g), 32'd2);

      // Line busy at reset release.
      req_data = $urandom;
      applyReset(1'b1, 4'b0100);
      sawRdy = 1'b0;
      repeat (5) begin
         toDrive;
         toSample;
         if (req_ready !== '0) sawRdy = 1'b1;
      end
      checkOutput("no_grant_while_busy", 32'(sawRdy), 32'd0);
      toDrive;
      tx_busy = 1'b0;
      toSample;
      applyStimulus(1'b0, 1'b0, g);
      checkOutput("grant_after_busy", 32'(g), 32'd2);

      // Reset in the 4th CRC cycle.
      applyReset(1'b0, '0);
      toDrive;
      req_valid = 4'b1000;
      req_data[31:24] = 8'($urandom);
      toSample;
      checkOutput("accept_r3", 32'(req_ready), 32'h8);
      toDrive;
      req_valid = '0;
      toSample;
      toDrive;
      toSample;
      toDrive;
      toSample;
      toDrive;
      reset = 1'b1;
      toSample;
      toDrive;
      reset = 1'b0;
      toSample;
      modelPtr = 0;
      checkOutput("midrst_req_ready", 32'(req_ready), 32'd0);
      checkOutput("midrst_tx_data", 32'(tx_data), 32'd0);
      checkOutput("midrst_tx_crc", 32'(tx_crc), 32'd0);
      checkOutput("midrst_tx_start", 32'(tx_start), 32'd0);
      checkOutput("midrst_grant_id", 32'(grant_id), 32'd0);
      checkOutput("midrst_frame_done", 32'(frame_done), 32'd0);
      checkOutput("midrst_launch_err", 32'(launch_err), 32'd0);
      toDrive;
      req_valid = 4'b0010;
      req_data[15:8] = 8'($urandom);
      toSample;
      applyStimulus(1'b0, 1'b0, g);
      checkOutput("post_reset_grant", 32'(g), 32'd1);

      // Randomized patterns, occasional launch timeout.
      for (int i = 0; i < 10; i++) begin
         toDrive;
         req_valid = N'($urandom_range(1, 15));
         req_data  = $urandom;
         toSample;
         applyStimulus($urandom_range(0, 4) == 0, 1'b0, g);
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
      $finish;
   end

endmodule
